id_ex_stage: RTL
================

# id_ex_stage

Decode-to-execute pipeline register of the segmented processor, sitting directly upstream of the 32-bit ALU. Each cycle it latches one decoded instruction, detects load-use hazards against the instruction already in EX, and applies EX/MEM and MEM/WB forwarding. It drives the ALU operands and ALU control, and carries memory and writeback control on to the EX/MEM register.

## Interface
- `DATA_W`, 32, operand/result width
- `REG_AW`, 5, register index width (register 0 is hard-wired zero)

- `clk` in 1: single clock, rising edge
- `reset` in 1: synchronous, active-low
- `id_valid` in 1: decode presents an instruction
- `id_rs1`, `id_rs2` in REG_AW: source indices
- `id_rd` in REG_AW: destination index
- `id_rs1_data`, `id_rs2_data` in DATA_W: register-file read data
- `id_imm` in DATA_W: sign-extended immediate
- `id_use_imm` in 1: operand 2 is the immediate
- `id_alu_ctrl` in 3: ALU opcode (010 add, 110 sub, 000 and, 001 or, 111 xor)
- `id_mem_read`, `id_mem_write`, `id_reg_write` in 1: downstream controls
- `flush` in 1: branch redirect; kill the instruction entering EX
- `exmem_rd` in REG_AW, `exmem_reg_write` in 1, `exmem_result` in DATA_W: EX/MEM forward source
- `memwb_rd` in REG_AW, `memwb_reg_write` in 1, `memwb_result` in DATA_W: MEM/WB forward source
- `stall` out 1: hold PC and IF/ID this cycle (combinational)
- `ex_valid` out 1: EX slot holds a live instruction
- `alu_data1`, `alu_data2` out DATA_W: forwarded ALU operands
- `alu_ctrl` out 3: ALU opcode
- `ex_store_data` out DATA_W: forwarded rs2 value for stores
- `ex_rd` out REG_AW; `ex_mem_read`, `ex_mem_write`, `ex_reg_write` out 1

## Operation
- **Pipeline register**
  - Captures every `id_*` field on each rising edge unless replaced by a bubble.
  - A bubble sets `ex_valid`, `ex_mem_read`, `ex_mem_write` and `ex_reg_write` to 0, sets `alu_ctrl` to 010, and clears the index fields to 0.
- **Load-use hazard**
  - Condition: `stall` = `id_valid` & `ex_valid` & `ex_mem_read` & `ex_rd`≠0 & (`ex_rd`==`id_rs1` | (`ex_rd`==`id_rs2` & !`id_use_imm`)).
  - Stores also compare rs2, regardless of `id_use_imm`.
  - On stall, a bubble enters EX. Decode holds its instruction, which is re-presented the next cycle.
- **Flush**
  - A bubble enters EX.
  - `flush` overrides stall: `stall` is forced to 0 while `flush`=1.
- **Forwarding** (combinational on registered indices and data, per source operand)
  - Priority 1: if `exmem_reg_write` & `exmem_rd`≠0 & `exmem_rd`==rs, use `exmem_result`.
  - Priority 2: else if `memwb_reg_write` & `memwb_rd`≠0 & `memwb_rd`==rs, use `memwb_result`.
  - Otherwise use the registered register-file data.
- **Operand 2 selection**
  - `alu_data2` = registered imm when use_imm=1, otherwise the forwarded rs2 value.
  - `ex_store_data` is always the forwarded rs2 value.
- **Register 0** is never a forward target. A read of rs=0 returns the registered data, which the register file supplies as 0.
- All data paths are DATA_W wide with no extension or truncation.

## Timing
- Latency: ID fields appear at the outputs 1 cycle after capture.
- Forwarded values are valid in the same cycle as the forward sources.
- Synchronous reset (`reset`=0 at a clock edge) loads a bubble:
  - `ex_valid`, `ex_mem_read`, `ex_mem_write`, `ex_reg_write` = 0
  - `alu_ctrl` = 010
  - `ex_rd` = 0
  - operand registers = 0
- During reset, `stall` = 0 because `ex_valid`=0.
- Reset mid-stall: the bubble wins and the stall releases in the next cycle.
- Forwarding logic is unaffected by reset apart from the cleared registered fields.
- Simultaneous EX/MEM and MEM/WB matches: EX/MEM wins.
- `stall` and `flush` in the same cycle: flush semantics apply and `stall` = 0.
- A stall lasts exactly one cycle per load-use pair. The following cycle forwards from EX/MEM once the load result is available there, or from MEM/WB per the system memory timing.

## Structure
- Shared package `cpu_pkg`:
  - ALU opcode constants (`ALU_ADD`=010, `ALU_SUB`=110, `ALU_AND`=000, `ALU_OR`=001, `ALU_XOR`=111)
  - `DATA_W`, `REG_AW`
  - packed struct for the ID/EX control bundle
- Sub-module `fwd_mux`: one forward selection (rs index, registered data, two sources → value). Instantiate it twice (rs1, rs2).
- Hazard compare and bubble logic live in the top module.

## Test plan
- **Plain pass-through:** after reset, present rs1=3 (data 5), rs2=4 (data 7), ctrl 010, no matches → next cycle `alu_data1`=5, `alu_data2`=7, `alu_ctrl`=010, `ex_valid`=1.
- **Forward priority:** EX holds rs1=3. With `exmem_rd`=3/`exmem_result`=0x10 and `memwb_rd`=3/`memwb_result`=0x20, both with reg_write → `alu_data1`=0x10. Drop exmem_reg_write → 0x20.
- **Register 0:** rs1=0, `exmem_rd`=0, exmem_reg_write=1, `exmem_result`=0xFFFF → `alu_data1`=registered data (0).
- **Load-use:** EX holds a load with rd=6; ID presents rs2=6, use_imm=0 → `stall`=1, next cycle `ex_valid`=0. The re-presented instruction then enters with `stall`=0.
- **Immediate path:** use_imm=1, imm=0xFFFFFFFC, rs2 forwarded as 9 → `alu_data2`=0xFFFFFFFC, `ex_store_data`=9. Load-use on rs2 of a non-store → no stall.
- **Flush/reset:** flush together with a load-use condition → `stall`=0 and a bubble enters EX. `reset`=0 mid-stream → all control outputs 0 and `alu_ctrl`=010 after the edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, ALU opcodes and the ID/EX control bundle.
package cpu_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_XOR = 3'b111;

  typedef struct packed {
    logic [2:0] alu_ctrl;
    logic       use_imm;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
  } idex_ctrl_t;

  // Control state of an empty EX slot: no side effects, harmless add.
  localparam idex_ctrl_t BUBBLE_CTRL = '{
    alu_ctrl:  ALU_ADD,
    use_imm:   1'b0,
    mem_read:  1'b0,
    mem_write: 1'b0,
    reg_write: 1'b0
  };

  // A later stage supplies a register only when it writes it and it is not x0.
  function automatic logic fwd_hit(input logic              we,
                                   input logic [REG_AW-1:0] src_rd,
                                   input logic [REG_AW-1:0] rs);
    return we && (src_rd != '0) && (src_rd == rs);
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode -> EX boundary bundle: decoded instruction, forward sources and EX-side outputs.
interface id_ex_stage_if;
  import cpu_pkg::*;

  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic [REG_AW-1:0] id_rd;
  logic [DATA_W-1:0] id_rs1_data;
  logic [DATA_W-1:0] id_rs2_data;
  logic [DATA_W-1:0] id_imm;
  logic              id_use_imm;
  logic [2:0]        id_alu_ctrl;
  logic              id_mem_read;
  logic              id_mem_write;
  logic              id_reg_write;
  logic              flush;

  logic [REG_AW-1:0] exmem_rd;
  logic              exmem_reg_write;
  logic [DATA_W-1:0] exmem_result;
  logic [REG_AW-1:0] memwb_rd;
  logic              memwb_reg_write;
  logic [DATA_W-1:0] memwb_result;

  logic              stall;
  logic              ex_valid;
  logic [DATA_W-1:0] alu_data1;
  logic [DATA_W-1:0] alu_data2;
  logic [2:0]        alu_ctrl;
  logic [DATA_W-1:0] ex_store_data;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_mem_read;
  logic              ex_mem_write;
  logic              ex_reg_write;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm,
           id_use_imm, id_alu_ctrl, id_mem_read, id_mem_write, id_reg_write, flush,
           exmem_rd, exmem_reg_write, exmem_result,
           memwb_rd, memwb_reg_write, memwb_result,
    input  stall, ex_valid, alu_data1, alu_data2, alu_ctrl, ex_store_data,
           ex_rd, ex_mem_read, ex_mem_write, ex_reg_write
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm,
           id_use_imm, id_alu_ctrl, id_mem_read, id_mem_write, id_reg_write, flush,
           exmem_rd, exmem_reg_write, exmem_result,
           memwb_rd, memwb_reg_write, memwb_result,
    output stall, ex_valid, alu_data1, alu_data2, alu_ctrl, ex_store_data,
           ex_rd, ex_mem_read, ex_mem_write, ex_reg_write
  );

endinterface

// File: rtl/fwd_mux.sv
// One source-operand forward selection: EX/MEM beats MEM/WB beats register-file data.
module fwd_mux
  import cpu_pkg::*;
(
  input  logic [REG_AW-1:0] rs,
  input  logic [DATA_W-1:0] reg_data,
  input  logic              exmem_reg_write,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_reg_write,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [DATA_W-1:0] memwb_result,
  output logic [DATA_W-1:0] value
);

  always_comb begin
    // NOTE: default assignment first so every path drives value and no latch is inferred.
    value = reg_data;
    if (fwd_hit(exmem_reg_write, exmem_rd, rs)) begin
      value = exmem_result;
    end else if (fwd_hit(memwb_reg_write, memwb_rd, rs)) begin
      value = memwb_result;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush bubbles and operand forwarding.
module id_ex_stage
  import cpu_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  id_ex_stage_if.slave bus
);

  logic              ex_valid_q;
  idex_ctrl_t        ctrl_q;
  logic [REG_AW-1:0] rs1_q;
  logic [REG_AW-1:0] rs2_q;
  logic [REG_AW-1:0] rd_q;
  logic [DATA_W-1:0] rs1_data_q;
  logic [DATA_W-1:0] rs2_data_q;
  logic [DATA_W-1:0] imm_q;

  idex_ctrl_t        id_ctrl;
  logic              rs1_hit;
  logic              rs2_hit;
  logic              load_use;
  logic              bubble;
  logic [DATA_W-1:0] rs1_fwd;
  logic [DATA_W-1:0] rs2_fwd;

  assign id_ctrl = '{
    alu_ctrl:  bus.id_alu_ctrl,
    use_imm:   bus.id_use_imm,
    mem_read:  bus.id_mem_read,
    mem_write: bus.id_mem_write,
    reg_write: bus.id_reg_write
  };

  // Stores read rs2 as store data even when operand 2 is the immediate.
  assign rs1_hit  = (rd_q == bus.id_rs1);
  assign rs2_hit  = (rd_q == bus.id_rs2) && (!bus.id_use_imm || bus.id_mem_write);
  assign load_use = bus.id_valid && ex_valid_q && ctrl_q.mem_read && (rd_q != '0)
                    && (rs1_hit || rs2_hit);

  // A flush discards the dependent instruction, so there is nothing to hold.
  assign bus.stall = load_use && !bus.flush;
  assign bubble    = !reset || bus.flush || load_use;

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every field updates from pre-edge values together.
    if (bubble) begin
      ex_valid_q <= 1'b0;
      ctrl_q     <= BUBBLE_CTRL;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
    end else begin
      ex_valid_q <= bus.id_valid;
      ctrl_q     <= id_ctrl;
      rs1_q      <= bus.id_rs1;
      rs2_q      <= bus.id_rs2;
      rd_q       <= bus.id_rd;
      rs1_data_q <= bus.id_rs1_data;
      rs2_data_q <= bus.id_rs2_data;
      imm_q      <= bus.id_imm;
    end
  end

  fwd_mux u_fwd_rs1 (
    .rs              (rs1_q),
    .reg_data        (rs1_data_q),
    .exmem_reg_write (bus.exmem_reg_write),
    .exmem_rd        (bus.exmem_rd),
    .exmem_result    (bus.exmem_result),
    .memwb_reg_write (bus.memwb_reg_write),
    .memwb_rd        (bus.memwb_rd),
    .memwb_result    (bus.memwb_result),
    .value           (rs1_fwd)
  );

  fwd_mux u_fwd_rs2 (
    .rs              (rs2_q),
    .reg_data        (rs2_data_q),
    .exmem_reg_write (bus.exmem_reg_write),
    .exmem_rd        (bus.exmem_rd),
    .exmem_result    (bus.exmem_result),
    .memwb_reg_write (bus.memwb_reg_write),
    .memwb_rd        (bus.memwb_rd),
    .memwb_result    (bus.memwb_result),
    .value           (rs2_fwd)
  );

  assign bus.ex_valid      = ex_valid_q;
  assign bus.alu_data1     = rs1_fwd;
  assign bus.alu_data2     = ctrl_q.use_imm ? imm_q : rs2_fwd;
  assign bus.ex_store_data = rs2_fwd;
  assign bus.alu_ctrl      = ctrl_q.alu_ctrl;
  assign bus.ex_rd         = rd_q;
  assign bus.ex_mem_read   = ctrl_q.mem_read;
  assign bus.ex_mem_write  = ctrl_q.mem_write;
  assign bus.ex_reg_write  = ctrl_q.reg_write;

endmodule
